// File: rtl/c64_pkg.sv
// ---------------------------------------------------------------------------
// c64_pkg
// Shared constants for the memory responder: the CPU address map (region
// base/limit pairs), the timer register offsets, the value returned for
// unmapped reads, and a helper that classifies a CPU address into a region.
// No ports; imported by mem_responder and c64_timer.
// ---------------------------------------------------------------------------
package c64_pkg;

  // Address map regions as seen on the 16-bit CPU bus
  localparam logic [15:0] RAM_BASE    = 16'h0000;
  localparam logic [15:0] RAM_LIMIT   = 16'h3FFF;
  localparam logic [15:0] TIMER_BASE  = 16'hD000;
  localparam logic [15:0] TIMER_LIMIT = 16'hD0FF;
  localparam logic [15:0] ROM_BASE    = 16'hFC00;
  localparam logic [15:0] ROM_LIMIT   = 16'hFFFF;

  // Read value for unmapped space and unused timer offsets
  localparam logic [7:0] UNMAPPED_VALUE = 8'hFF;

  // Timer register offsets (ab[2:0] inside the timer window)
  localparam logic [2:0] TMR_LATCH_LO = 3'd0;
  localparam logic [2:0] TMR_LATCH_HI = 3'd1;
  localparam logic [2:0] TMR_CTRL     = 3'd2;
  localparam logic [2:0] TMR_STATUS   = 3'd3;
  localparam logic [2:0] TMR_COUNT_LO = 3'd4;
  localparam logic [2:0] TMR_COUNT_HI = 3'd5;

  typedef enum logic [1:0] {
    REGION_NONE  = 2'd0,
    REGION_RAM   = 2'd1,
    REGION_TIMER = 2'd2,
    REGION_ROM   = 2'd3
  } region_t;

  function automatic logic in_range(input logic [15:0] addr,
                                    input logic [15:0] base,
                                    input logic [15:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

  function automatic region_t decode_region(input logic [15:0] addr);
    if (in_range(addr, RAM_BASE, RAM_LIMIT))
      return REGION_RAM;
    else if (in_range(addr, TIMER_BASE, TIMER_LIMIT))
      return REGION_TIMER;
    else if (in_range(addr, ROM_BASE, ROM_LIMIT))
      return REGION_ROM;
    else
      return REGION_NONE;
  endfunction

endpackage

// File: rtl/c64_timer.sv
// ---------------------------------------------------------------------------
// c64_timer
// 16-bit down-counting interval timer with a 16-bit reload latch, a control
// register (run / continuous) and a sticky underflow flag that drives irq.
//
// Ports:
//   clk    - clock, all state changes on its rising edge
//   reset  - synchronous, active-low
//   sel    - CPU address currently falls in the timer window
//   we     - CPU write enable (1 = write)
//   addr   - register offset (ab[2:0])
//   wdata  - CPU write data
//   rdata  - combinational register read data
//   irq    - level interrupt, equal to the underflow flag
// ---------------------------------------------------------------------------
module c64_timer
  import c64_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq
);

  logic [15:0] latch;
  logic [15:0] counter;
  logic        run;
  logic        cont;
  logic        flag;

  logic        wr;
  logic        status_rd;

  assign wr        = sel && we;
  assign status_rd = sel && !we && (addr == TMR_STATUS);

  // A ctrl write overrides the counting step for that edge. The flag is
  // cleared by a status read first, so an underflow on the same edge wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      latch   <= 16'hFFFF;
      counter <= 16'h0000;
      run     <= 1'b0;
      cont    <= 1'b0;
      flag    <= 1'b0;
    end else begin
      if (wr && addr == TMR_LATCH_LO) latch[7:0]  <= wdata;
      if (wr && addr == TMR_LATCH_HI) latch[15:8] <= wdata;

      if (status_rd) flag <= 1'b0;

      if (wr && addr == TMR_CTRL) begin
        cont <= wdata[1];
        run  <= wdata[0];
        if (wdata[0]) counter <= latch;
      end else if (run) begin
        if (counter != 16'h0000) begin
          counter <= counter - 16'h0001;
        end else begin
          flag <= 1'b1;
          if (cont) counter <= latch;
          else      run     <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rdata = UNMAPPED_VALUE;
    unique case (addr)
      TMR_LATCH_LO: rdata = latch[7:0];
      TMR_LATCH_HI: rdata = latch[15:8];
      TMR_CTRL:     rdata = {6'b0, cont, run};
      TMR_STATUS:   rdata = {6'b0, run, flag};
      TMR_COUNT_LO: rdata = counter[7:0];
      TMR_COUNT_HI: rdata = counter[15:8];
      default:      rdata = UNMAPPED_VALUE;
    endcase
  end

  assign irq = flag;

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Memory/peripheral responder for a simple 8-bit CPU: RAM (mirrored through
// $0000-$3FFF), a timer (mirrored through $D000-$D0FF) and a ROM at
// $FC00-$FFFF that is preloaded through a side port.
//
// Ports:
//   clk       - clock
//   reset     - synchronous, active-low (does not clear RAM/ROM contents)
//   ab        - CPU address bus
//   cpu_do    - CPU write data
//   we        - CPU write enable (1 = write)
//   di        - read data to the CPU, combinational from ab
//   load_en   - ROM preload strobe
//   load_addr - ROM preload address
//   load_data - ROM preload data
//   irq       - timer interrupt, active-high level
// ---------------------------------------------------------------------------
module mem_responder
  import c64_pkg::*;
#(
  parameter int RAM_AW = 11,
  parameter int ROM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       ab,
  input  logic [7:0]        cpu_do,
  input  logic              we,
  output logic [7:0]        di,
  input  logic              load_en,
  input  logic [ROM_AW-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              irq
);

  logic [7:0] ram [0:(1<<RAM_AW)-1];
  logic [7:0] rom [0:(1<<ROM_AW)-1];

  region_t    region;
  logic [7:0] timer_rdata;

  assign region = decode_region(ab);

  // RAM writes are blocked while reset is asserted; the array itself is
  // never cleared, so its contents survive reset.
  always_ff @(posedge clk) begin
    if (reset && we && region == REGION_RAM)
      ram[ab[RAM_AW-1:0]] <= cpu_do;
  end

  // The preload port is independent of the CPU bus and of reset. CPU
  // writes to ROM have no path here and are dropped.
  always_ff @(posedge clk) begin
    if (load_en)
      rom[load_addr] <= load_data;
  end

  c64_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .sel   (region == REGION_TIMER),
    .we    (we),
    .addr  (ab[2:0]),
    .wdata (cpu_do),
    .rdata (timer_rdata),
    .irq   (irq)
  );

  // Zero-latency read path: the CPU samples di on the edge after it
  // registers ab, so the arrays are read asynchronously.
  always_comb begin
    di = UNMAPPED_VALUE;
    unique case (region)
      REGION_RAM:   di = ram[ab[RAM_AW-1:0]];
      REGION_TIMER: di = timer_rdata;
      REGION_ROM:   di = rom[ab[ROM_AW-1:0]];
      default:      di = UNMAPPED_VALUE;
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder: RAM mirroring, ROM preload, address map
// boundaries, timer one-shot / continuous / status collision, and reset.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  localparam int RAM_AW = 11;
  localparam int ROM_AW = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       ab;
  logic [7:0]        cpu_do;
  logic              we;
  logic [7:0]        di;
  logic              load_en;
  logic [ROM_AW-1:0] load_addr;
  logic [7:0]        load_data;
  logic              irq;

  int vectors     = 0;
  int miscompares = 0;

  mem_responder #(.RAM_AW(RAM_AW), .ROM_AW(ROM_AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ab        (ab),
    .cpu_do    (cpu_do),
    .we        (we),
    .di        (di),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Drive the bus and let the combinational read path settle
  task automatic setBus(input logic [15:0] a, input logic w, input logic [7:0] d);
    ab = a;
    we = w;
    cpu_do = d;
    #1;
  endtask

  // Advance one rising edge and sample just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete bus cycle
  task automatic applyStimulus(input logic [15:0] a, input logic w, input logic [7:0] d);
    setBus(a, w, d);
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkRead(input string tag, input logic [15:0] a,
                           input logic [7:0] expected);
    setBus(a, 1'b0, 8'h00);
    checkOutput(tag, di, expected);
  endtask

  task automatic checkIrq(input string tag, input logic expected);
    checkOutput(tag, {7'b0, irq}, {7'b0, expected});
  endtask

  initial begin
    reset = 1'b0;
    load_en = 1'b0;
    load_addr = '0;
    load_data = 8'h00;
    setBus(16'h0000, 1'b0, 8'h00);
    tick();
    tick();
    reset = 1'b1;

    // Reset state
    checkIrq("reset_irq", 1'b0);
    checkRead("reset_latch_lo", 16'hD000, 8'hFF);
    checkRead("reset_latch_hi", 16'hD001, 8'hFF);
    checkRead("reset_ctrl", 16'hD002, 8'h00);
    checkRead("reset_status", 16'hD003, 8'h00);
    checkRead("reset_count_lo", 16'hD004, 8'h00);

    // RAM and its mirrors
    applyStimulus(16'h0123, 1'b1, 8'h5A);
    checkRead("ram_mirror_0923", 16'h0923, 8'h5A);
    checkRead("ram_direct_0123", 16'h0123, 8'h5A);
    applyStimulus(16'h3FFF, 1'b1, 8'hC3);
    checkRead("ram_mirror_07ff", 16'h07FF, 8'hC3);
    checkRead("unmapped_4000", 16'h4000, 8'hFF);

    // ROM preload, ignored CPU write, preload/read overlap
    load_en = 1'b1;
    load_addr = 10'h3FC;
    load_data = 8'hA9;
    tick();
    load_en = 1'b0;
    applyStimulus(16'hFFFC, 1'b1, 8'h00);
    checkRead("rom_fffc", 16'hFFFC, 8'hA9);
    load_en = 1'b1;
    load_data = 8'hB7;
    checkRead("rom_old_during_load", 16'hFFFC, 8'hA9);
    tick();
    load_en = 1'b0;
    checkRead("rom_new_after_load", 16'hFFFC, 8'hB7);
    checkRead("unmapped_5000", 16'h5000, 8'hFF);
    checkRead("unmapped_fbff", 16'hFBFF, 8'hFF);
    checkRead("unmapped_cfff", 16'hCFFF, 8'hFF);
    checkRead("unmapped_d100", 16'hD100, 8'hFF);
    checkRead("timer_off6", 16'hD006, 8'hFF);
    checkRead("timer_mirror_off7", 16'hD00F, 8'hFF);
    checkRead("timer_mirror_latch", 16'hD0F8, 8'hFF);

    // One-shot: latch 3
    applyStimulus(16'hD000, 1'b1, 8'h03);
    applyStimulus(16'hD001, 1'b1, 8'h00);
    applyStimulus(16'hD002, 1'b1, 8'h01);
    checkRead("os_count3", 16'hD004, 8'h03);
    tick();
    checkOutput("os_count2", di, 8'h02);
    tick();
    checkOutput("os_count1", di, 8'h01);
    tick();
    checkOutput("os_count0", di, 8'h00);
    checkIrq("os_irq_before", 1'b0);
    tick();
    checkIrq("os_irq_set", 1'b1);
    checkOutput("os_count_hold", di, 8'h00);
    checkRead("os_ctrl_stopped", 16'hD002, 8'h00);
    tick();
    checkRead("os_count_still0", 16'hD004, 8'h00);
    checkRead("os_status", 16'hD003, 8'h01);
    tick();
    checkIrq("os_irq_cleared", 1'b0);

    // Continuous: latch 2
    applyStimulus(16'hD000, 1'b1, 8'h02);
    applyStimulus(16'hD001, 1'b1, 8'h00);
    applyStimulus(16'hD002, 1'b1, 8'h03);
    checkRead("ct_count2a", 16'hD004, 8'h02);
    checkIrq("ct_irq0", 1'b0);
    tick();
    checkOutput("ct_count1a", di, 8'h01);
    tick();
    checkOutput("ct_count0a", di, 8'h00);
    checkIrq("ct_irq_pre", 1'b0);
    tick();
    checkOutput("ct_count2b", di, 8'h02);
    checkIrq("ct_irq_set", 1'b1);
    tick();
    checkOutput("ct_count1b", di, 8'h01);
    tick();
    checkOutput("ct_count0b", di, 8'h00);
    tick();
    checkOutput("ct_count2c", di, 8'h02);

    // Status read colliding with an underflow
    checkRead("col_status_03", 16'hD003, 8'h03);
    tick();
    checkIrq("col_cleared", 1'b0);
    tick();
    checkOutput("col_status_02", di, 8'h02);
    tick();
    checkIrq("col_set_wins", 1'b1);
    checkOutput("col_status_after", di, 8'h03);
    tick();
    checkIrq("col_next_clears", 1'b0);

    // Latch 0 continuous: underflow every cycle, flag stays set
    applyStimulus(16'hD002, 1'b1, 8'h00);
    applyStimulus(16'hD003, 1'b0, 8'h00);
    checkIrq("z_irq_clear", 1'b0);
    applyStimulus(16'hD000, 1'b1, 8'h00);
    applyStimulus(16'hD001, 1'b1, 8'h00);
    applyStimulus(16'hD002, 1'b1, 8'h03);
    checkRead("z_status_run", 16'hD003, 8'h02);
    tick();
    checkIrq("z_irq_a", 1'b1);
    checkOutput("z_status_a", di, 8'h03);
    tick();
    checkIrq("z_irq_b", 1'b1);
    checkRead("z_count", 16'hD004, 8'h00);

    // ctrl write with run=0 holds the counter
    applyStimulus(16'hD000, 1'b1, 8'h05);
    applyStimulus(16'hD002, 1'b1, 8'h01);
    checkRead("h_count5", 16'hD004, 8'h05);
    tick();
    checkOutput("h_count4", di, 8'h04);
    applyStimulus(16'hD002, 1'b1, 8'h00);
    checkRead("h_held4", 16'hD004, 8'h04);
    tick();
    checkOutput("h_still4", di, 8'h04);
    checkRead("h_ctrl", 16'hD002, 8'h00);

    // Reset mid-count with a same-cycle RAM write and ROM preload
    applyStimulus(16'hD002, 1'b1, 8'h03);
    tick();
    setBus(16'h0123, 1'b1, 8'h00);
    reset = 1'b0;
    load_en = 1'b1;
    load_addr = 10'h3FC;
    load_data = 8'hC6;
    tick();
    reset = 1'b1;
    load_en = 1'b0;
    checkRead("rst_ctrl", 16'hD002, 8'h00);
    checkIrq("rst_irq", 1'b0);
    checkRead("rst_latch_lo", 16'hD000, 8'hFF);
    checkRead("rst_latch_hi", 16'hD001, 8'hFF);
    checkRead("rst_status", 16'hD003, 8'h00);
    checkRead("rst_ram_intact", 16'h0923, 8'h5A);
    checkRead("rst_rom_preload", 16'hFFFC, 8'hC6);
    checkRead("rst_count", 16'hD004, 8'h00);
    tick();
    checkOutput("rst_count_hold", di, 8'h00);
    checkIrq("rst_irq_hold", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
